// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and the hex -> 7-segment lookup used by the
//               scan driver. Segment vectors are active-high {g,f,e,d,c,b,a}
//               with bit 0 = segment a.
// Contents    : DIGITS   - number of multiplexed digits on the board
//               DIG_W    - width of the digit index
//               SEG_OFF  - active-high "all segments dark" pattern
//               hex_to_seg() - 16-entry hex glyph table
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam int         DIGITS  = 4;
  localparam int         DIG_W   = $clog2(DIGITS);
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Hex glyph table, active-high gfedcba. Lower-case b and d keep them
  // distinguishable from 8 and 0. Anything that is not a clean 0..F (X/Z
  // in simulation) falls through to a dark digit rather than a guess.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] glyph;
    glyph = SEG_OFF;
    case (nib)
      4'h0:    glyph = 7'b0111111;
      4'h1:    glyph = 7'b0000110;
      4'h2:    glyph = 7'b1011011;
      4'h3:    glyph = 7'b1001111;
      4'h4:    glyph = 7'b1100110;
      4'h5:    glyph = 7'b1101101;
      4'h6:    glyph = 7'b1111101;
      4'h7:    glyph = 7'b0000111;
      4'h8:    glyph = 7'b1111111;
      4'h9:    glyph = 7'b1101111;
      4'hA:    glyph = 7'b1110111;
      4'hB:    glyph = 7'b1111100;
      4'hC:    glyph = 7'b0111001;
      4'hD:    glyph = 7'b1011110;
      4'hE:    glyph = 7'b1111001;
      4'hF:    glyph = 7'b1110001;
      default: glyph = SEG_OFF;
    endcase
    return glyph;
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational 4-bit hex nibble to 7-segment glyph decoder.
//               Output is always active-high; pin polarity is applied by the
//               instantiating scan driver just ahead of its output flops.
// Ports       : nibble   in  4  hex digit to render
//               segments out 7  active-high {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = hex_to_seg(nibble);

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed 4-digit hex 7-segment driver. A 16-bit value
//               is captured into a shadow register on load, copied to the
//               display register only at the end of a full scan frame (so a
//               frame never mixes two values), and scanned one digit per slot
//               with a programmable anode dead time at the start of each slot.
//               All pins are registered: they reflect the scan state of the
//               previous clock cycle.
// Ports       : clk    in  1   system clock
//               rst_n  in  1   asynchronous active-low reset
//               value  in  16  hex value; value[3:0] is digit 0 (an[0])
//               load   in  1   capture value/dp_in into the shadow register
//               dp_in  in  4   per-digit decimal point request
//               seg    out 7   segment pins {g,f,e,d,c,b,a}
//               dp     out 1   decimal point pin of the active digit
//               an     out 4   digit anode pins, one-hot active or all idle
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int               REFRESH_DIV    = 100000,
  parameter int               BLANK_CYCLES   = 1000,
  parameter logic [DIGITS-1:0] DIGIT_EN      = 4'b1011,
  parameter bit               ACTIVE_LOW_SEG = 1'b1,
  parameter bit               ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0]  c_dig_last = DIG_W'(DIGITS - 1);

  // Idle (dark) pin levels in board polarity; also the reset values.
  localparam logic [6:0]        c_seg_idle = ACTIVE_LOW_SEG ? ~SEG_OFF : SEG_OFF;
  localparam logic              c_dp_idle  = ACTIVE_LOW_SEG;
  localparam logic [DIGITS-1:0] c_an_idle  = ACTIVE_LOW_AN ? {DIGITS{1'b1}}
                                                           : {DIGITS{1'b0}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]    r_cnt;        // position inside the current digit slot
  logic [DIG_W-1:0]    r_digit;      // digit currently being scanned
  logic [4*DIGITS-1:0] r_shadow;     // last value captured on load
  logic [DIGITS-1:0]   r_shadow_dp;
  logic [4*DIGITS-1:0] r_disp;       // value shown for the whole current frame
  logic [DIGITS-1:0]   r_disp_dp;

  // --------------------------------------------------------------------------
  // Scan timing
  // --------------------------------------------------------------------------
  logic w_slot_end;
  logic w_frame_end;
  logic w_blank;

  assign w_slot_end  = (r_cnt == c_cnt_last);
  assign w_frame_end = w_slot_end && (r_digit == c_dig_last);

  // With no dead time the compare would be a constant-false unsigned test,
  // so that case is tied off explicitly.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] c_blank_len = CNT_W'(BLANK_CYCLES);
      assign w_blank = (r_cnt < c_blank_len);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Digit selection and decode
  // --------------------------------------------------------------------------
  logic [3:0]        w_nibble;
  logic              w_dp_req;
  logic [DIGITS-1:0] w_an_onehot;
  logic              w_active;
  logic [6:0]        w_glyph;

  always_comb begin
    w_nibble    = r_disp[3:0];
    w_dp_req    = r_disp_dp[0];
    w_an_onehot = {{(DIGITS-1){1'b0}}, 1'b1};
    case (r_digit)
      2'd0: begin
        w_nibble    = r_disp[3:0];
        w_dp_req    = r_disp_dp[0];
        w_an_onehot = 4'b0001;
      end
      2'd1: begin
        w_nibble    = r_disp[7:4];
        w_dp_req    = r_disp_dp[1];
        w_an_onehot = 4'b0010;
      end
      2'd2: begin
        w_nibble    = r_disp[11:8];
        w_dp_req    = r_disp_dp[2];
        w_an_onehot = 4'b0100;
      end
      default: begin
        w_nibble    = r_disp[15:12];
        w_dp_req    = r_disp_dp[3];
        w_an_onehot = 4'b1000;
      end
    endcase
  end

  // A masked digit still consumes its slot but never lights: the anode,
  // segment and dp selection below depend only on the enable mask and the
  // scan counters, so a garbage nibble behind a masked digit cannot leak.
  assign w_active = !w_blank && DIGIT_EN[r_digit];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble   (w_nibble),
    .segments (w_glyph)
  );

  // --------------------------------------------------------------------------
  // Next pin values, polarity applied ahead of the output flops
  // --------------------------------------------------------------------------
  logic [6:0]        w_seg_hi;
  logic              w_dp_hi;
  logic [DIGITS-1:0] w_an_hi;
  logic [6:0]        w_seg_pin;
  logic              w_dp_pin;
  logic [DIGITS-1:0] w_an_pin;

  assign w_seg_hi  = w_active ? w_glyph : SEG_OFF;
  assign w_dp_hi   = w_active & w_dp_req;
  assign w_an_hi   = w_active ? w_an_onehot : {DIGITS{1'b0}};

  assign w_seg_pin = ACTIVE_LOW_SEG ? ~w_seg_hi : w_seg_hi;
  assign w_dp_pin  = ACTIVE_LOW_SEG ? ~w_dp_hi  : w_dp_hi;
  assign w_an_pin  = ACTIVE_LOW_AN  ? ~w_an_hi  : w_an_hi;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_digit     <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
      seg         <= c_seg_idle;
      dp          <= c_dp_idle;
      an          <= c_an_idle;
    end else begin
      // Prescaler and digit ring; the ring wraps naturally at DIGITS=4.
      if (w_slot_end) begin
        r_cnt   <= '0;
        r_digit <= r_digit + 1'b1;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end

      if (load) begin
        r_shadow    <= value;
        r_shadow_dp <= dp_in;
      end

      // Non-blocking read of r_shadow: a load on the latch edge itself is
      // deliberately deferred to the following frame.
      if (w_frame_end) begin
        r_disp    <= r_shadow;
        r_disp_dp <= r_shadow_dp;
      end

      seg <= w_seg_pin;
      dp  <= w_dp_pin;
      an  <= w_an_pin;
    end
  end

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver. Three instances
//               share clock and stimulus: dut_a (all digits, active-low pins),
//               dut_b (digit 2 masked, active-low), dut_c (all digits,
//               active-high pins). REFRESH_DIV=8, BLANK_CYCLES=2, so a frame
//               is 32 cycles. After reset release, the pins seen just after
//               edge n reflect scan state n-1: slot d = ((n-1)/8)%4 and
//               cnt = (n-1)%8; frame f spans edges 32f+1..32f+32 and shows the
//               value latched at edge 32f.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int c_div = 8;
  localparam int c_blk = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dp_in = 4'b0000;

  logic [6:0]  seg_a, seg_b, seg_c;
  logic        dp_a, dp_b, dp_c;
  logic [3:0]  an_a, an_b, an_c;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(c_div), .BLANK_CYCLES(c_blk), .DIGIT_EN(4'b1111),
                     .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .seg(seg_a), .dp(dp_a), .an(an_a));

  seg7_scan_driver #(.REFRESH_DIV(c_div), .BLANK_CYCLES(c_blk), .DIGIT_EN(4'b1011),
                     .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .seg(seg_b), .dp(dp_b), .an(an_b));

  seg7_scan_driver #(.REFRESH_DIV(c_div), .BLANK_CYCLES(c_blk), .DIGIT_EN(4'b1111),
                     .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .seg(seg_c), .dp(dp_c), .an(an_c));

  // Never more than one anode lit on any instance.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(~an_a) > 1 || $countones(~an_b) > 1 || $countones(an_c) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t: got an_a=%b an_b=%b an_c=%b, required at most one active",
                 $time, an_a, an_b, an_c);
      end
    end
  end

  typedef struct {
    int          e;     // edge number after reset release
    int          dut;   // 0=a 1=b 2=c 3=no check (load only)
    bit          ld;    // capture val/dpv at this edge
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int e, input int dut, input bit ld, input logic [15:0] val,
                     input logic [3:0] dpv, input logic [3:0] an, input logic [6:0] sg,
                     input logic d);
    vec_t v;
    v.e = e; v.dut = dut; v.ld = ld; v.val = val; v.dpv = dpv;
    v.an = an; v.seg = sg; v.dp = d;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic cmp(input string nm, input int dut, input logic [3:0] an_e,
                     input logic [6:0] seg_e, input logic dp_e);
    logic [3:0] an_g;
    logic [6:0] seg_g;
    logic       dp_g;
    case (dut)
      0:       begin an_g = an_a; seg_g = seg_a; dp_g = dp_a; end
      1:       begin an_g = an_b; seg_g = seg_b; dp_g = dp_b; end
      default: begin an_g = an_c; seg_g = seg_c; dp_g = dp_c; end
    endcase
    checks++;
    if (an_g !== an_e || seg_g !== seg_e || dp_g !== dp_e) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
               nm, dut, edge_n, an_g, seg_g, dp_g, an_e, seg_e, dp_e);
    end
  endtask

  int blanks[4];
  int pos_bad;
  int dp_bad;

  initial begin
    // Directed vectors. Active-low glyphs: 0=40 1=79 2=24 3=30 F=0E A=08 8=00.
    // Active-high glyphs: 1->06 2=5B 3=4F 8=7F.
    add( 37, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h40, 1'b1); // frame1: shadow was reset -> '0'
    add( 40, 3, 1, 16'h3012, 4'h0, 4'h0, 7'h00, 1'b0); // load 3012
    add( 65, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 1'b1); // slot0 cnt0 blank
    add( 66, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 1'b1); // slot0 cnt1 blank
    add( 67, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h24, 1'b1); // slot0 first lit cycle '2'
    add( 69, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h24, 1'b1);
    add( 69, 2, 0, 16'h0000, 4'h0, 4'h1, 7'h5B, 1'b0); // active-high '2'
    add( 77, 0, 0, 16'h0000, 4'h0, 4'hD, 7'h79, 1'b1); // '1'
    add( 81, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 1'b1); // slot2 cnt0 blank
    add( 83, 0, 0, 16'h0000, 4'h0, 4'hB, 7'h40, 1'b1); // '0'
    add( 85, 0, 0, 16'h0000, 4'h0, 4'hB, 7'h40, 1'b1);
    add( 85, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 1'b1); // masked digit 2
    add( 93, 0, 0, 16'h0000, 4'h0, 4'h7, 7'h30, 1'b1); // '3'
    add( 93, 1, 0, 16'h0000, 4'h0, 4'h7, 7'h30, 1'b1);
    add(107, 3, 1, 16'hFFFF, 4'h0, 4'h0, 7'h00, 1'b0); // load FFFF mid frame3 slot1
    add(117, 0, 0, 16'h0000, 4'h0, 4'hB, 7'h40, 1'b1); // no tear: still '0'
    add(125, 0, 0, 16'h0000, 4'h0, 4'h7, 7'h30, 1'b1); // still '3'
    add(133, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h0E, 1'b1); // frame4 all F
    add(141, 0, 0, 16'h0000, 4'h0, 4'hD, 7'h0E, 1'b1);
    add(149, 0, 0, 16'h0000, 4'h0, 4'hB, 7'h0E, 1'b1);
    add(157, 0, 0, 16'h0000, 4'h0, 4'h7, 7'h0E, 1'b1);
    add(160, 3, 1, 16'hAAAA, 4'h0, 4'h0, 7'h00, 1'b0); // load on the latch edge
    add(165, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h0E, 1'b1); // frame5 keeps old F
    add(189, 0, 0, 16'h0000, 4'h0, 4'h7, 7'h0E, 1'b1);
    add(197, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h08, 1'b1); // frame6 shows A
    add(197, 2, 0, 16'h0000, 4'h0, 4'h1, 7'h77, 1'b0);
    add(200, 3, 1, 16'h3x12, 4'h0, 4'h0, 7'h00, 1'b0); // load with unknown nibble 2
    add(213, 0, 0, 16'h0000, 4'h0, 4'hB, 7'h08, 1'b1);
    add(229, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h24, 1'b1); // frame7: 3x12
    add(232, 3, 1, 16'h8888, 4'b0100, 4'h0, 7'h00, 1'b0); // load 8888 with dp on digit 2
    add(237, 0, 0, 16'h0000, 4'h0, 4'hD, 7'h79, 1'b1);
    add(241, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 1'b1);
    add(245, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 1'b1); // X nibble masked
    add(253, 1, 0, 16'h0000, 4'h0, 4'h7, 7'h30, 1'b1);
    add(261, 2, 0, 16'h0000, 4'h0, 4'h1, 7'h7F, 1'b0); // frame8 active-high '8'
    add(273, 2, 0, 16'h0000, 4'h0, 4'h0, 7'h00, 1'b0); // active-high idle in blank
    add(277, 0, 0, 16'h0000, 4'h0, 4'hB, 7'h00, 1'b0); // active-low dp lit
    add(277, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 1'b1); // masked digit: dp stays off
    add(277, 2, 0, 16'h0000, 4'h0, 4'h4, 7'h7F, 1'b1); // dp only on an=0100
    add(285, 2, 0, 16'h0000, 4'h0, 4'h8, 7'h7F, 1'b0);

    // ---------------- Reset mid-scan ----------------
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    value  = 16'h3012;
    load   = 1'b1;
    step();
    load   = 1'b0;
    while (edge_n < 40) step();
    cmp("prereset_scan", 0, 4'hE, 7'h24, 1'b1);
    rst_n = 1'b0;
    #1;
    cmp("reset_async", 0, 4'hF, 7'h7F, 1'b1);
    cmp("reset_async", 2, 4'h0, 7'h00, 1'b0);
    repeat (3) step();
    cmp("reset_hold", 0, 4'hF, 7'h7F, 1'b1);
    rst_n  = 1'b1;
    edge_n = 0;
    step();
    cmp("release_blank1", 0, 4'hF, 7'h7F, 1'b1);
    step();
    cmp("release_blank2", 0, 4'hF, 7'h7F, 1'b1);
    step();
    cmp("release_first", 0, 4'hE, 7'h40, 1'b1);
    cmp("release_first", 2, 4'h1, 7'h3F, 1'b0);

    // ---------------- Table ----------------
    foreach (vecs[i]) begin
      while (edge_n < vecs[i].e - 1) step();
      if (vecs[i].ld) begin
        value = vecs[i].val;
        dp_in = vecs[i].dpv;
        load  = 1'b1;
      end
      if (edge_n < vecs[i].e) step();
      load = 1'b0;
      if (vecs[i].dut < 3) cmp("vec", vecs[i].dut, vecs[i].an, vecs[i].seg, vecs[i].dp);
    end

    // ---------------- Dead time over frame 9 (edges 289..320) ----------------
    while (edge_n < 288) step();
    for (int k = 0; k < 4; k++) blanks[k] = 0;
    pos_bad = 0;
    dp_bad  = 0;
    for (int n = 289; n <= 320; n++) begin
      step();
      if (an_a == 4'hF) blanks[(n - 289) / 8]++;
      if ((an_a == 4'hF) != (((n - 1) % 8) < 2)) pos_bad++;
      if (dp_c !== (an_c == 4'b0100)) dp_bad++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (blanks[k] != 2) begin
        errors++;
        $display("FAIL deadtime slot%0d: got %0d idle cycles, required 2", k, blanks[k]);
      end
    end
    checks++;
    if (pos_bad != 0) begin
      errors++;
      $display("FAIL deadtime_position: got %0d misplaced cycles, required 0", pos_bad);
    end
    checks++;
    if (dp_bad != 0) begin
      errors++;
      $display("FAIL dp_follows_anode: got %0d bad cycles, required 0", dp_bad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seg7_scan_driver
`default_nettype wire
